arbiter_8_rr: RTL
=================

# arbiter_8_rr

Round-robin arbiter that shares one downstream resource between eight requesters. It turns an 8-bit request vector into a registered one-hot grant and a 3-bit grant index, which is the encoded form produced by the team's 8-to-3 encoder. A grant is held until the owner releases it, and priority rotates so no requester starves. The block sits between the requesting units and the shared datapath's select/enable inputs.

## Interface
- `HOLD_MAX`, 16: maximum grant length in cycles. Used only when timeout is compiled in. Legal range 2..255.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  arbiter enable. When low, no new grant is issued and any current grant is released.
- `req`  in  8  request lines. `req[i]` is level-held by requester i until it is served.
- `done`  in  1  single-cycle release pulse from the current owner.
- `gnt`  out  8  one-hot grant, registered.
- `gnt_id`  out  3  binary index of the granted requester; 3'b000 when `valid`=0.
- `valid`  out  1  a grant is active.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- The state machine has two states, IDLE and GRANT, plus a 3-bit rotation pointer `ptr`.
- **Reset:** state=IDLE, `ptr`=0, `gnt`=8'h00, `gnt_id`=3'b000, `valid`=0, `timeout`=0, hold counter=0.
- **IDLE:**
  - If `en`=1 and `req`≠0, pick the first set bit scanning `ptr`, `ptr`+1, … , 7, 0, … , `ptr`-1 (mod 8).
  - Load `gnt`, `gnt_id` and `valid`=1, then go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT:** the grant is released on the clock edge where any of the following holds:
  - `done`=1, or
  - `req[gnt_id]`=0, or
  - `en`=0, or
  - timeout (see Configuration).
- **On release:**
  - `gnt`=0, `valid`=0, `gnt_id`=0, and the state returns to IDLE.
  - `ptr` = `gnt_id`+1, wrapping 7→0.
- Outputs are never tri-stated. A disabled or idle arbiter drives zeros.
- Changes on `req` bits other than the owner's are ignored during GRANT.
- `done` asserted while in IDLE is ignored.
- Simultaneous release conditions: `done` or a dropped request takes precedence over timeout. In that case `timeout` stays 0.

## Timing
- **Grant latency:** a request sampled at edge N while in IDLE gives `gnt`/`valid` high after edge N, i.e. visible during cycle N+1.
- **Release:** a release condition sampled at edge M drops `gnt` after edge M.
- **Bubble:** every release is followed by at least one IDLE cycle. The earliest next grant is after edge M+1.
- **Back-to-back:** with all 8 requesting and each owner pulsing `done` on its first grant cycle, each requester is served once per 16 cycles.
- **Reset mid-grant:** asynchronous. `gnt`/`valid` fall immediately without waiting for a clock edge. `ptr` returns to 0.
- **Hold counter:** cleared on entering GRANT and incremented each GRANT cycle. Width is 8 bits.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined:**
  - If the owner is still in GRANT when the hold counter reaches `HOLD_MAX`-1, the grant is released on that edge.
  - `timeout` pulses high for the one following cycle.
  - `ptr` advances normally, so the timed-out requester goes to the back of the rotation.
  - The maximum grant length is therefore `HOLD_MAX` cycles.
- **Undefined:**
  - The hold counter and timeout logic are not built.
  - `timeout` is tied to 0.
  - A grant lasts until `done`, a dropped request, or `en`=0.

## Test plan
- **Reset values:** `rst_n`=0 with `req`=8'hFF → `gnt`=0, `gnt_id`=0, `valid`=0, `timeout`=0. Release reset with `en`=1 → `gnt`=8'h01, `gnt_id`=0 one cycle later.
- **Rotation:** `req`=8'hFF held, `done` pulsed on each grant's first cycle → `gnt_id` sequence 0,1,2,…,7,0, with one idle cycle between grants.
- **Wrap and skip:** serve requester 5 (`ptr`=6), then `req`=8'b0000_0110 → `gnt_id`=1 (scan 6,7,0,1), then `gnt_id`=2.
- **Enable:** `en`=0 during a grant of requester 3 → `gnt` drops after that edge and `ptr`=4. `en`=0 with `req`≠0 in IDLE → no grant for 10 cycles.
- **Timeout (`ARB_TIMEOUT_EN`, `HOLD_MAX`=4):** `req`=8'h10 held with no `done` → `gnt`=8'h10 for exactly 4 cycles, `timeout` high for 1 cycle, regrant after 1 idle cycle. Without the macro → grant held indefinitely and `timeout`=0.
- **Async reset mid-grant:** `rst_n` driven low between clock edges → `valid` low before the next edge, and `ptr` restarts at 0.

Source files
------------

// File: rtl/arbiter_8_rr.sv
// Eight-way round-robin arbiter with registered one-hot grant, encoded grant index
// and rotating priority. Optional forced release after HOLD_MAX cycles via `ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; scan req from ptr and grant the first set bit
// S_GRANT | gnt_id owns the resource until done, request drop, en low
//         | or (with ARB_TIMEOUT_EN) the hold counter expires
module arbiter_8_rr #(
   parameter int HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       valid,
   output logic       timeout
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] gnt_id_q, gnt_id_d;
   logic [7:0] gnt_q, gnt_d;

   logic [2:0] scan_idx;
   logic [2:0] pick_id;
   logic       owner_req;
   logic       tmo_hit;

   if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_check
      $error("arbiter_8_rr: HOLD_MAX must be in 2..255");
   end

   // Scan from the highest offset down so the lowest offset from ptr wins.
   always_comb begin
      scan_idx = 3'd0;
      pick_id  = ptr_q;
      for (int i = 7; i >= 0; i--) begin
         scan_idx = ptr_q + 3'(i);
         if (req[scan_idx]) begin
            pick_id = scan_idx;
         end
      end
   end

   assign owner_req = req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       timeout_q, timeout_d;

   assign tmo_hit = (hold_cnt_q == HOLD_LAST);

   always_comb begin
      hold_cnt_d = 8'd0;
      timeout_d  = 1'b0;
      if (state_q == S_GRANT) begin
         hold_cnt_d = hold_cnt_q + 8'd1;
         // A voluntary release in the same cycle wins; no timeout is reported then.
         timeout_d  = tmo_hit & ~done & owner_req;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= 8'd0;
         timeout_q  <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_id_d = gnt_id_q;
      gnt_d    = gnt_q;
      case (state_q)
         S_IDLE: begin
            if (en && (req != 8'h00)) begin
               state_d  = S_GRANT;
               gnt_id_d = pick_id;
               gnt_d    = 8'h01 << pick_id;
            end
         end
         S_GRANT: begin
            if (done || !owner_req || !en || tmo_hit) begin
               state_d  = S_IDLE;
               ptr_d    = gnt_id_q + 3'd1;
               gnt_id_d = 3'd0;
               gnt_d    = 8'h00;
            end
         end
         default: begin
            state_d  = S_IDLE;
            gnt_id_d = 3'd0;
            gnt_d    = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= 3'd0;
         gnt_id_q <= 3'd0;
         gnt_q    <= 8'h00;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_id_q <= gnt_id_d;
         gnt_q    <= gnt_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign valid  = (state_q == S_GRANT);

endmodule
